// File: rtl/seg7_pkg.sv
// Seven-segment code constants and single-digit decode, shared by the digit encoder/decoder blocks.
// Latency: combinational helper only.
// Backpressure: not applicable.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0011000;
    localparam logic [6:0] SEG_2     = 7'b1110110;
    localparam logic [6:0] SEG_3     = 7'b1111100;
    localparam logic [6:0] SEG_4     = 7'b1011001;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1101111;
    localparam logic [6:0] SEG_7     = 7'b0111000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111101;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Returns {illegal, bcd}. Illegal codes decode to bcd 0 so downstream
    // arithmetic never sees garbage. The blank code is accepted as 0 only
    // when the caller says blanking is allowed for this digit position.
    function automatic logic [4:0] seg7_decode(input logic [6:0] code, input logic blank_ok);
        logic [4:0] res;
        case (code)
            SEG_0:   res = 5'b0_0000;
            SEG_1:   res = 5'b0_0001;
            SEG_2:   res = 5'b0_0010;
            SEG_3:   res = 5'b0_0011;
            SEG_4:   res = 5'b0_0100;
            SEG_5:   res = 5'b0_0101;
            SEG_6:   res = 5'b0_0110;
            SEG_7:   res = 5'b0_0111;
            SEG_8:   res = 5'b0_1000;
            SEG_9:   res = 5'b0_1001;
            default: res = (blank_ok && (code == SEG_BLANK)) ? 5'b0_0000 : 5'b1_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg7_dec_cell.sv
// Registered single-digit seven-segment to BCD decoder (first pipeline stage).
// Latency: 1 cycle; data registers load only when en is high.
// Backpressure: none, accepts a code every cycle.
module seg7_dec_cell
    import seg7_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       en,
    input  logic [6:0] code,
    input  logic       blank_ok,
    output logic [3:0] bcd,
    output logic       illegal
);

    // Capture the decoded digit and its illegal flag on valid cycles only.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            bcd     <= 4'd0;
            illegal <= 1'b0;
        end else if (en) begin
            {illegal, bcd} <= seg7_decode(code, blank_ok);
        end
    end

endmodule

// File: rtl/decdigi2hex_8bit.sv
// Three seven-segment digits (hundreds/tens/units) to 8-bit binary, with illegal/overflow flag and saturating error count.
// Latency: 3 cycles (decode, partial product, final sum), one conversion per cycle.
// Backpressure: none; bubbles propagate. Optional leading-zero blanking via DECDIGI2HEX_BLANK_EN.
module decdigi2hex_8bit
    import seg7_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [6:0]           digi_2,
    input  logic [6:0]           digi_1,
    input  logic [6:0]           digi_0,
    input  logic                 err_clr,
    output logic                 out_valid,
    output logic [7:0]           out_hex,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    logic       blank_ok_2;
    logic       blank_ok_1;
    logic       blank_ok_0;

    // Blanking is only meaningful for leading zeros: hundreds always, tens
    // only under a blank hundreds, units never.
`ifdef DECDIGI2HEX_BLANK_EN
    assign blank_ok_2 = 1'b1;
    assign blank_ok_1 = (digi_2 == SEG_BLANK);
`else
    assign blank_ok_2 = 1'b0;
    assign blank_ok_1 = 1'b0;
`endif
    assign blank_ok_0 = 1'b0;

    // Stage 1: per-digit decode
    logic       s1_valid;
    logic [3:0] s1_bcd_2;
    logic [3:0] s1_bcd_1;
    logic [3:0] s1_bcd_0;
    logic       s1_ill_2;
    logic       s1_ill_1;
    logic       s1_ill_0;

    seg7_dec_cell u_dec_2 (
        .clock    (clock),
        .rst_n    (rst_n),
        .en       (in_valid),
        .code     (digi_2),
        .blank_ok (blank_ok_2),
        .bcd      (s1_bcd_2),
        .illegal  (s1_ill_2)
    );

    seg7_dec_cell u_dec_1 (
        .clock    (clock),
        .rst_n    (rst_n),
        .en       (in_valid),
        .code     (digi_1),
        .blank_ok (blank_ok_1),
        .bcd      (s1_bcd_1),
        .illegal  (s1_ill_1)
    );

    seg7_dec_cell u_dec_0 (
        .clock    (clock),
        .rst_n    (rst_n),
        .en       (in_valid),
        .code     (digi_0),
        .blank_ok (blank_ok_0),
        .bcd      (s1_bcd_0),
        .illegal  (s1_ill_0)
    );

    // Stage 1 valid tracks the request; bubbles become empty slots.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= in_valid;
        end
    end

    // Stage 2: hundreds*100 + tens*10 (max 990, fits in 10 bits)
    logic       s2_valid;
    logic [9:0] s2_partial;
    logic [3:0] s2_units;
    logic       s2_err;
    logic [9:0] s1_partial;

    assign s1_partial = ({6'd0, s1_bcd_2} * 10'd100) + ({6'd0, s1_bcd_1} * 10'd10);

    // Register the partial sum and carry units plus the combined illegal flag.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_partial <= 10'd0;
            s2_units   <= 4'd0;
            s2_err     <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_partial <= s1_partial;
                s2_units   <= s1_bcd_0;
                s2_err     <= s1_ill_2 | s1_ill_1 | s1_ill_0;
            end
        end
    end

    // Stage 3: final sum, range check and result registers
    logic [9:0] s2_sum;
    logic       s2_fail;

    assign s2_sum  = s2_partial + {6'd0, s2_units};
    assign s2_fail = s2_err || (s2_sum > 10'd255);

    // Result registers hold between valid results; errors force zero.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_hex   <= 8'h00;
            out_err   <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_hex <= s2_fail ? 8'h00 : s2_sum[7:0];
                out_err <= s2_fail;
            end
        end
    end

    // Saturating error counter, updated on the same edge as the failing result; clear wins.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (s2_valid && s2_fail && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + CNT_ONE;
        end
    end

endmodule
